layer_argmax_10_16: RTL and testbench
=====================================

// Module: layer_argmax_10_16
// PURPOSE
//  Downstream stage of the 10-output, 16-bit layer. Consumes the layer's
//  M ReLU outputs per input vector over a valid/ready stream and tracks the
//  running maximum and its index. After the M-th output it presents the
//  winning class index and value on a valid/ready result port.
// PARAMETERS
//  M        10  outputs per frame (must be >= 2)
//  DATA_W   16  signed sample width
//  IDX_W    4   index width, = $clog2(M)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  s_valid    in   1       upstream sample valid
//  s_ready    out  1       this block accepts a sample this cycle
//  data_in    in   DATA_W  signed sample (upstream data_out)
//  m_valid    out  1       result valid
//  m_ready    in   1       downstream accepts result
//  class_out  out  IDX_W   index 0..M-1 of the maximum sample
//  max_out    out  DATA_W  value of the maximum sample
// BEHAVIOUR
//  - Reset (async, any cycle, including mid-frame or mid-output): state=ACCUM,
//    cnt=0, run_max=0, run_idx=0, s_ready=0 while reset is high, m_valid=0,
//    class_out=0, max_out=0. s_ready=1 from the first clock after release.
//  - Transfer: a sample is taken only on a clk edge with s_valid && s_ready.
//    A result is taken only on a clk edge with m_valid && m_ready.
//  - FSM with two states:
//    ACCUM:  s_ready=1, m_valid=0. On each transfer:
//            cnt==0 -> run_max=data_in, run_idx=0 (unconditional load)
//            else if $signed(data_in) > $signed(run_max) -> run_max=data_in,
//              run_idx=cnt (strict compare: a tie keeps the lower index)
//            cnt==M-1 -> load class_out/max_out from the final compare
//              (including this sample), cnt=0, go to OUTPUT
//            else cnt=cnt+1. Idle cycles (s_valid=0) change nothing.
//    OUTPUT: s_ready=0, m_valid=1. class_out/max_out stay stable until
//            the handshake. On m_ready=1 -> ACCUM (s_ready=1 next cycle).
//            Stalls indefinitely while m_ready=0. Upstream data held with
//            s_valid=1 is not consumed.
//  - Latency: m_valid rises on the edge that accepts sample M-1 (visible
//    the next cycle). Minimum frame period is M+1 cycles (M samples + 1
//    result cycle).
//  - Arithmetic: all compares are signed DATA_W. Negative values are
//    handled correctly even though ReLU inputs are >= 0. No saturation.
//  - cnt wraps only at M-1 -> 0. It never reaches M.
//  - m_valid does not depend combinationally on m_ready. s_ready depends
//    on state only.
// STRUCTURE
//  - Shared package nn_pkg: DATA_W, M, IDX_W constants and
//    typedef enum logic {ACCUM, OUTPUT} argmax_state_t.
//  - One sub-module, argmax_cmp (combinational): inputs cur_max, cur_idx,
//    sample, cnt, first. Outputs nxt_max, nxt_idx. It implements the
//    load/strict-greater rule.
//  - The top level holds the FSM, the counter, the run_* registers and the
//    output registers.
// TESTING
//  1. Frame {5,9,3,9,0,1,2,8,7,4}, m_ready=1 -> class_out=1, max_out=9
//     (tie keeps index 1). m_valid high exactly one cycle.
//  2. Frame of all zeros -> class_out=0, max_out=0. Frame with 127 at
//     index 9 only -> class_out=9, max_out=127.
//  3. Signed check: {-5,-3,-9,-3,-20,-1,-7,-8,-2,-4} -> class_out=5,
//     max_out=-1.
//  4. Backpressure: hold m_ready=0 for 20 cycles with the next frame's
//     s_valid=1 -> s_ready=0 and outputs stable throughout. After m_ready=1
//     the next frame is accepted and its result is correct.
//  5. Gaps: randomly deassert s_valid within a frame -> same result as the
//     gap-free frame, and cnt does not advance on idle cycles.
//  6. Reset after sample 4 of a frame, then a full frame {1,2,...,10}
//     -> m_valid=0 during reset, then class_out=9, max_out=10, with no
//     leftover state from the partial frame.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared constants and state type for the 10-output, 16-bit layer.
package nn_pkg;
  localparam int M = 10;
  localparam int DATA_W = 16;
  localparam int IDX_W = $clog2(M);
  typedef enum logic {ACCUM, OUTPUT} argmax_state_t;
endpackage

// File: rtl/argmax_cmp.sv
// argmax_cmp: combinational running-max update; the first sample loads, later samples replace only when strictly greater.
module argmax_cmp
  import nn_pkg::*;
(
  input  logic signed [DATA_W-1:0] cur_max,
  input  logic        [IDX_W-1:0]  cur_idx,
  input  logic signed [DATA_W-1:0] sample,
  input  logic        [IDX_W-1:0]  cnt,
  input  logic                     first,
  output logic signed [DATA_W-1:0] nxt_max,
  output logic        [IDX_W-1:0]  nxt_idx
);
  logic w_take;
  always_comb begin
    w_take  = first || (sample > cur_max);
    nxt_max = w_take ? sample : cur_max;
    nxt_idx = w_take ? cnt : cur_idx;
  end
endmodule

// File: rtl/layer_argmax_10_16.sv
// layer_argmax_10_16: streams M signed samples per frame and emits the index and value of the frame maximum.
module layer_argmax_10_16
  import nn_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic        [IDX_W-1:0]  class_out,
  output logic signed [DATA_W-1:0] max_out
);
  argmax_state_t r_state;
  logic        [IDX_W-1:0]  r_cnt, r_run_idx, r_class, w_nxt_idx;
  logic signed [DATA_W-1:0] r_run_max, r_max, w_nxt_max;
  logic                     r_s_ready, r_m_valid, w_take, w_first, w_last;
  assign w_take    = s_valid && r_s_ready;
  assign w_first   = r_cnt == '0;
  assign w_last    = r_cnt == IDX_W'(M - 1);
  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign class_out = r_class;
  assign max_out   = r_max;
  argmax_cmp u_cmp (
    .cur_max (r_run_max),
    .cur_idx (r_run_idx),
    .sample  (data_in),
    .cnt     (r_cnt),
    .first   (w_first),
    .nxt_max (w_nxt_max),
    .nxt_idx (w_nxt_idx)
  );
  // s_ready is registered so it stays low while reset is held and rises one clock after release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ACCUM;
      r_cnt     <= '0;
      r_run_max <= '0;
      r_run_idx <= '0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_class   <= '0;
      r_max     <= '0;
    end else if (r_state == ACCUM) begin
      r_s_ready <= 1'b1;
      if (w_take) begin
        r_run_max <= w_nxt_max;
        r_run_idx <= w_nxt_idx;
        r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_class   <= w_nxt_idx;
          r_max     <= w_nxt_max;
          r_state   <= OUTPUT;
          r_s_ready <= 1'b0;
          r_m_valid <= 1'b1;
        end
      end
    end else if (m_ready) begin
      r_state   <= ACCUM;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_layer_argmax_10_16.sv
// tb_layer_argmax_10_16: directed and random frames checked against a max-then-lowest-index reference model.
module tb_layer_argmax_10_16;
  import nn_pkg::*;
  typedef logic signed [DATA_W-1:0] frame_t [M];
  logic clk = 0, reset = 1, s_valid = 0, m_ready = 0;
  logic signed [DATA_W-1:0] data_in = '0;
  logic s_ready, m_valid;
  logic [IDX_W-1:0] class_out;
  logic signed [DATA_W-1:0] max_out;
  int cmp_n = 0, err_n = 0;
  layer_argmax_10_16 dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
    .m_valid(m_valid), .m_ready(m_ready), .class_out(class_out), .max_out(max_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input frame_t f, output int idx, output logic signed [DATA_W-1:0] mx);
    mx = f[0];
    foreach (f[i]) if (f[i] > mx) mx = f[i];
    idx = -1;
    foreach (f[i]) if (idx < 0 && f[i] == mx) idx = i;
  endfunction
  task automatic send_sample(input logic signed [DATA_W-1:0] v);
    bit got = 0;
    int n = 0;
    s_valid = 1;
    data_in = v;
    while (!got && n < 64) begin
      @(negedge clk);
      got = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 0;
    chk("accept", 32'(got), 1);
  endtask
  task automatic send_frame(input frame_t f, input int gap_pct);
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < 4 && int'($urandom_range(99)) < gap_pct; j++) begin
        @(posedge clk);
        #1;
      end
      send_sample(f[i]);
      if (i < M - 1) chk("early_valid", 32'(m_valid), 0);
    end
  endtask
  task automatic check_result(input string tag, input frame_t f, input int hold, input bit keep,
                              input logic signed [DATA_W-1:0] nxt);
    int eidx;
    logic signed [DATA_W-1:0] emax;
    model(f, eidx, emax);
    chk({tag, "_valid"}, 32'(m_valid), 1);
    chk({tag, "_class"}, 32'(class_out), 32'(eidx));
    chk({tag, "_max"}, 32'(max_out), 32'(emax));
    chk({tag, "_sready"}, 32'(s_ready), 0);
    if (keep) begin
      s_valid = 1;
      data_in = nxt;
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk({tag, "_stall_valid"}, 32'(m_valid), 1);
      chk({tag, "_stall_sready"}, 32'(s_ready), 0);
      chk({tag, "_stall_class"}, 32'(class_out), 32'(eidx));
      chk({tag, "_stall_max"}, 32'(max_out), 32'(emax));
    end
    m_ready = 1;
    @(posedge clk);
    #1;
    m_ready = 0;
    chk({tag, "_drop"}, 32'(m_valid), 0);
    chk({tag, "_ready_back"}, 32'(s_ready), 1);
  endtask
  initial begin
    frame_t f, g, h;
    #2;
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_sready", 32'(s_ready), 0);
    chk("rst_class", 32'(class_out), 0);
    chk("rst_max", 32'(max_out), 0);
    @(posedge clk);
    #1;
    reset = 0;
    chk("rel_sready_low", 32'(s_ready), 0);
    @(posedge clk);
    #1;
    chk("rel_sready_high", 32'(s_ready), 1);
    f = '{5, 9, 3, 9, 0, 1, 2, 8, 7, 4};
    send_frame(f, 0);
    check_result("tie", f, 0, 0, 0);
    f = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(f, 0);
    check_result("zeros", f, 0, 0, 0);
    f = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 127};
    send_frame(f, 0);
    check_result("last", f, 0, 0, 0);
    f = '{-5, -3, -9, -3, -20, -1, -7, -8, -2, -4};
    g = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    send_frame(f, 0);
    check_result("signed_bp", f, 20, 1, g[0]);
    send_frame(g, 0);
    check_result("after_bp", g, 0, 0, 0);
    foreach (g[i]) g[i] = DATA_W'($urandom_range(0, 9));
    send_frame(g, 0);
    check_result("nogap", g, 0, 0, 0);
    send_frame(g, 40);
    check_result("gap", g, 0, 0, 0);
    h = '{50, 60, 70, 80, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) send_sample(h[i]);
    #3 reset = 1;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 0);
    chk("mid_rst_sready", 32'(s_ready), 0);
    @(posedge clk);
    #1;
    chk("mid_rst_valid2", 32'(m_valid), 0);
    chk("mid_rst_max", 32'(max_out), 0);
    reset = 0;
    f = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    send_frame(f, 0);
    check_result("post_rst", f, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      foreach (g[i]) g[i] = (k % 2 == 0) ? DATA_W'($urandom_range(0, 7)) : DATA_W'($urandom);
      send_frame(g, (k % 3) * 25);
      check_result("rand", g, int'($urandom_range(0, 3)), 0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
